// File: rtl/alu_result_queue.sv
// alu_result_queue
//   Small FIFO that buffers ALU results (result, opcode, {N,Z,V} flags)
//   behind a valid/ready handshake, plus sticky status flags for the
//   issuing controller.
//
//   Optional feature: define ALU_RESULT_OVF_COUNT_EN to add the ovf_count
//   output, a saturating 16-bit count of pushes carrying in_overflow = 1.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/ready    upstream handshake; in_ready = (level != DEPTH)
//   in_result/opcode  ALU result and the opcode that produced it
//   in_negative/zero/overflow  ALU flags captured with the entry
//   out_valid/ready   downstream handshake; out_valid = (level != 0)
//   out_result/opcode/flags    combinational read of the head entry
//   level             current occupancy
//   clear_sticky      synchronous clear of sticky state (a push wins)
//   sticky_flags      OR of flags of all entries accepted since clear/reset
//   ovf_count         (ALU_RESULT_OVF_COUNT_EN only) overflow push counter

module alu_result_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int OP_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_result,
    input  logic [OP_W-1:0]          in_opcode,
    input  logic                     in_negative,
    input  logic                     in_zero,
    input  logic                     in_overflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_result,
    output logic [OP_W-1:0]          out_opcode,
    output logic [2:0]               out_flags,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     clear_sticky,
    output logic [2:0]               sticky_flags
`ifdef ALU_RESULT_OVF_COUNT_EN
    ,
    output logic [15:0]              ovf_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_result [DEPTH];
    logic [OP_W-1:0]   mem_opcode [DEPTH];
    logic [2:0]        mem_flags  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [2:0]        in_flags;
    logic              push;
    logic              pop;

    // Handshake status depends only on the registered occupancy.
    always_comb begin
        in_ready  = (level != LVL_W'(DEPTH));
        out_valid = (level != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        in_flags  = {in_negative, in_zero, in_overflow};
    end

    // Head entry is presented combinationally; no bypass from the input.
    always_comb begin
        out_result = mem_result[rd_ptr];
        out_opcode = mem_opcode[rd_ptr];
        out_flags  = mem_flags[rd_ptr];
    end

    // Storage, pointers and occupancy. Pointers wrap naturally because
    // DEPTH is a power of two; level disambiguates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_result[i] <= '0;
                mem_opcode[i] <= '0;
                mem_flags[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_result[wr_ptr] <= in_result;
                mem_opcode[wr_ptr] <= in_opcode;
                mem_flags[wr_ptr]  <= in_flags;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Sticky flags: a push in the same cycle as a clear leaves exactly the
    // pushed flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
        end else if (push) begin
            sticky_flags <= clear_sticky ? in_flags : (sticky_flags | in_flags);
        end else if (clear_sticky) begin
            sticky_flags <= '0;
        end
    end

`ifdef ALU_RESULT_OVF_COUNT_EN
    // Saturating overflow counter; an overflowing push during a clear
    // restarts the count at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (clear_sticky) begin
            ovf_count <= (push && in_overflow) ? 16'd1 : 16'd0;
        end else if (push && in_overflow && (ovf_count != '1)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
module tb_alu_result_queue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int OP_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_result = '0;
    logic [OP_W-1:0]   in_opcode = '0;
    logic              in_negative = 1'b0;
    logic              in_zero = 1'b0;
    logic              in_overflow = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_result;
    logic [OP_W-1:0]   out_opcode;
    logic [2:0]        out_flags;
    logic [2:0]        level;
    logic              clear_sticky = 1'b0;
    logic [2:0]        sticky_flags;
`ifdef ALU_RESULT_OVF_COUNT_EN
    logic [15:0]       ovf_count;
`endif

    alu_result_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_opcode(in_opcode),
        .in_negative(in_negative), .in_zero(in_zero), .in_overflow(in_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_opcode(out_opcode), .out_flags(out_flags),
        .level(level), .clear_sticky(clear_sticky), .sticky_flags(sticky_flags)
`ifdef ALU_RESULT_OVF_COUNT_EN
        , .ovf_count(ovf_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a queue of entries plus the sticky/overflow rules.
    typedef struct {
        logic [DATA_W-1:0] result;
        logic [OP_W-1:0]   opcode;
        logic [2:0]        flags;
    } entry_t;

    entry_t   q[$];
    logic [2:0] m_sticky = '0;
    int         m_ovf = 0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sticky = '0;
        m_ovf = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":level"}, 64'(level), 64'(q.size()));
        chk({tag, ":in_ready"}, 64'(in_ready), 64'(q.size() < DEPTH));
        chk({tag, ":out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        chk({tag, ":sticky"}, 64'(sticky_flags), 64'(m_sticky));
        if (q.size() > 0) begin
            chk({tag, ":out_result"}, 64'(out_result), 64'(q[0].result));
            chk({tag, ":out_opcode"}, 64'(out_opcode), 64'(q[0].opcode));
            chk({tag, ":out_flags"}, 64'(out_flags), 64'(q[0].flags));
        end
`ifdef ALU_RESULT_OVF_COUNT_EN
        chk({tag, ":ovf_count"}, 64'(ovf_count), 64'(m_ovf));
`endif
    endtask

    // One clock cycle: drive inputs, advance the model across the edge,
    // then check at the following falling edge.
    task automatic cycle(input string tag, input logic vld, input logic [DATA_W-1:0] res,
                         input logic [OP_W-1:0] op, input logic [2:0] f,
                         input logic rdy, input logic clr);
        entry_t e;
        bit do_push;
        bit do_pop;
        in_valid = vld; in_result = res; in_opcode = op;
        {in_negative, in_zero, in_overflow} = f;
        out_ready = rdy; clear_sticky = clr;
        do_push = vld && (q.size() < DEPTH);
        do_pop  = rdy && (q.size() > 0);
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            e.result = res; e.opcode = op; e.flags = f;
            q.push_back(e);
        end
        if (clr) m_sticky = do_push ? f : 3'b000;
        else if (do_push) m_sticky = m_sticky | f;
        if (clr) m_ovf = (do_push && f[0]) ? 1 : 0;
        else if (do_push && f[0] && m_ovf < 65535) m_ovf++;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle_drain(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) cycle(tag, 1'b0, '0, '0, 3'b000, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rst:out_valid", 64'(out_valid), 64'd0);
        chk("rst:in_ready", 64'(in_ready), 64'd1);
        chk("rst:level", 64'(level), 64'd0);
        chk("rst:sticky", 64'(sticky_flags), 64'd0);
        chk("rst:out_result", 64'(out_result), 64'd0);
        chk("rst:out_opcode", 64'(out_opcode), 64'd0);
        chk("rst:out_flags", 64'(out_flags), 64'd0);

        // Single push, 1-cycle latency
        cycle("push1", 1'b1, 32'h9999CCCC, 4'h4, 3'b101, 1'b0, 1'b0);
        chk("push1:out_valid", 64'(out_valid), 64'd1);
        chk("push1:out_result", 64'(out_result), 64'h9999CCCC);
        chk("push1:out_flags", 64'(out_flags), 64'b101);
        chk("push1:level", 64'(level), 64'd1);
        chk("push1:sticky", 64'(sticky_flags), 64'b101);
        idle_drain("drain1");

        // Fill, overfill, drain in order
        for (int i = 1; i <= 5; i++)
            cycle("fill", 1'b1, DATA_W'(i), OP_W'(i), 3'b000, 1'b0, 1'b0);
        chk("full:in_ready", 64'(in_ready), 64'd0);
        chk("full:level", 64'(level), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("drain:order", 64'(out_result), 64'(i));
            cycle("drain", 1'b0, '0, '0, 3'b000, 1'b1, 1'b0);
        end
        chk("drained:out_valid", 64'(out_valid), 64'd0);

        // Steady level 2 with simultaneous push/pop, pointers wrapping
        cycle("lvl2", 1'b1, 32'd100, 4'h1, 3'b000, 1'b0, 1'b0);
        cycle("lvl2", 1'b1, 32'd101, 4'h2, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("lvl2:head", 64'(out_result), 64'(100 + i));
            cycle("lvl2", 1'b1, DATA_W'(102 + i), OP_W'(i), 3'b010, 1'b1, 1'b0);
            chk("lvl2:level", 64'(level), 64'd2);
        end
        idle_drain("drain2");

        // Sticky clear racing a push
        cycle("clr", 1'b0, '0, '0, 3'b000, 1'b0, 1'b1);
        cycle("zpush", 1'b1, 32'h11, 4'h3, 3'b010, 1'b0, 1'b0);
        cycle("clr_v", 1'b1, 32'h22, 4'h5, 3'b001, 1'b0, 1'b1);
        chk("clr_v:sticky", 64'(sticky_flags), 64'b001);
`ifdef ALU_RESULT_OVF_COUNT_EN
        chk("clr_v:ovf_count", 64'(ovf_count), 64'd1);
`endif
        idle_drain("drain3");

        // Asynchronous reset mid-transfer at level 3
        for (int i = 0; i < 3; i++)
            cycle("pre_rst", 1'b1, DATA_W'(32'hA0 + i), 4'h6, 3'b111, 1'b0, 1'b0);
        in_valid = 1'b1; out_ready = 1'b1; in_result = 32'hDEAD;
        #2 rst = 1'b1;
        #1;
        chk("async_rst:out_valid", 64'(out_valid), 64'd0);
        chk("async_rst:level", 64'(level), 64'd0);
        chk("async_rst:in_ready", 64'(in_ready), 64'd1);
        chk("async_rst:sticky", 64'(sticky_flags), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle("post_rst", 1'b1, 32'h0BADF00D, 4'h9, 3'b100, 1'b0, 1'b0);
        chk("post_rst:out_result", 64'(out_result), 64'h0BADF00D);
        idle_drain("drain4");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++)
            cycle("rand", 1'($urandom_range(0, 1)), DATA_W'($urandom), OP_W'($urandom),
                  3'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        idle_drain("drain5");

`ifdef ALU_RESULT_OVF_COUNT_EN
        // Saturation of the overflow counter
        cycle("sat_clr", 1'b0, '0, '0, 3'b000, 1'b1, 1'b1);
        for (int i = 0; i < 65540; i++)
            cycle("sat", 1'b1, DATA_W'(i), 4'h7, 3'b001, 1'b1, 1'b0);
        chk("sat:ovf_count", 64'(ovf_count), 64'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20_000_000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
